axi_lite_cmd_arbiter: RTL and testbench

//  Shares one AXI4-Lite master port among N_REQ PL-side requesters issuing single-word register reads/writes.

---
 rtl/axi_lite_cmd_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_axi_lite_cmd_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among N_REQ requesters.
// One transaction outstanding at a time, with a per-transaction response timeout.
module axi_lite_cmd_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                       pl_clk_i,
  input  logic                       pl_rst_i,
  // Requester side
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ-1:0]           req_write_i,
  input  logic [32*N_REQ-1:0]        req_addr_i,
  input  logic [32*N_REQ-1:0]        req_wdata_i,
  input  logic [4*N_REQ-1:0]         req_wstrb_i,
  output logic [N_REQ-1:0]           rsp_valid_o,
  output logic [31:0]                rsp_rdata_o,
  output logic [1:0]                 rsp_resp_o,
  output logic                       busy_o,
  output logic [$clog2(N_REQ)-1:0]   grant_id_o,
  // AXI4-Lite master
  output logic [31:0]                m_axi_awaddr_o,
  output logic                       m_axi_awvalid_o,
  input  logic                       m_axi_awready_i,
  output logic [31:0]                m_axi_wdata_o,
  output logic [3:0]                 m_axi_wstrb_o,
  output logic                       m_axi_wvalid_o,
  input  logic                       m_axi_wready_i,
  input  logic [1:0]                 m_axi_bresp_i,
  input  logic                       m_axi_bvalid_i,
  output logic                       m_axi_bready_o,
  output logic [31:0]                m_axi_araddr_o,
  output logic                       m_axi_arvalid_o,
  input  logic                       m_axi_arready_i,
  input  logic [31:0]                m_axi_rdata_i,
  input  logic [1:0]                 m_axi_rresp_i,
  input  logic                       m_axi_rvalid_i,
  output logic                       m_axi_rready_o
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StResp, StDrain} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   grant_q, grant_d, winner, cand;
  logic             found;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d, ready, grant_oh;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]       rsp_resp_q, rsp_resp_d;
  logic             resp_phase, rsp_hs, expired;
  logic [31:0]      addr_a  [N_REQ];
  logic [31:0]      wdata_a [N_REQ];
  logic [3:0]       wstrb_a [N_REQ];

  // Unpack the flat requester buses into per-requester arrays
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      addr_a[k]  = req_addr_i[k*32 +: 32];
      wdata_a[k] = req_wdata_i[k*32 +: 32];
      wstrb_a[k] = req_wstrb_i[k*4 +: 4];
    end
  end

  // Round-robin search starting just after the last owner
  always_comb begin
    found  = 1'b0;
    winner = grant_q;
    cand   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IdW'((32'(grant_q) + i) % N_REQ);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
  assign resp_phase = (state_q == StResp) || (state_q == StDrain);
  assign m_axi_bready_o = resp_phase && wr_q;
  assign m_axi_rready_o = resp_phase && !wr_q;
  assign rsp_hs  = (m_axi_bvalid_i && m_axi_bready_o) || (m_axi_rvalid_i && m_axi_rready_o);
  // A zero TIMEOUT never expires
  assign expired = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  // Next-state, command capture and response generation
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    ar_pend_d   = ar_pend_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    ready       = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          ready[winner] = 1'b1;
          grant_d   = winner;
          wr_d      = req_write_i[winner];
          addr_d    = addr_a[winner];
          wdata_d   = wdata_a[winner];
          wstrb_d   = wstrb_a[winner];
          aw_pend_d = req_write_i[winner];
          w_pend_d  = req_write_i[winner];
          ar_pend_d = !req_write_i[winner];
          cnt_d     = '0;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        cnt_d     = cnt_q + 1'b1;
        aw_pend_d = aw_pend_q && !m_axi_awready_i;
        w_pend_d  = w_pend_q && !m_axi_wready_i;
        ar_pend_d = ar_pend_q && !m_axi_arready_i;
        if (expired) begin
          rsp_valid_d = grant_oh;
          rsp_rdata_d = '0;
          rsp_resp_d  = 2'b11;
          state_d     = StDrain;
        end else if (!aw_pend_d && !w_pend_d && !ar_pend_d) begin
          state_d = StResp;
        end
      end
      StResp: begin
        cnt_d = cnt_q + 1'b1;
        // A response landing on the expiry cycle is reported normally
        if (rsp_hs) begin
          rsp_valid_d = grant_oh;
          rsp_rdata_d = wr_q ? 32'h0 : m_axi_rdata_i;
          rsp_resp_d  = wr_q ? m_axi_bresp_i : m_axi_rresp_i;
          state_d     = StIdle;
        end else if (expired) begin
          rsp_valid_d = grant_oh;
          rsp_rdata_d = '0;
          rsp_resp_d  = 2'b11;
          state_d     = StDrain;
        end
      end
      StDrain: begin
        aw_pend_d = aw_pend_q && !m_axi_awready_i;
        w_pend_d  = w_pend_q && !m_axi_wready_i;
        ar_pend_d = ar_pend_q && !m_axi_arready_i;
        // Late response is swallowed
        if (rsp_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge pl_clk_i or posedge pl_rst_i) begin
    if (pl_rst_i) begin
      state_q     <= StIdle;
      grant_q     <= IdW'(N_REQ - 1);
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      ar_pend_q   <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      ar_pend_q   <= ar_pend_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Ready is combinational from IDLE, so mask it while reset is held
  assign req_ready_o     = ready & {N_REQ{!pl_rst_i}};
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_resp_o      = rsp_resp_q;
  assign busy_o          = (state_q != StIdle);
  assign grant_id_o      = grant_q;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = wstrb_q;
  assign m_axi_awvalid_o = aw_pend_q;
  assign m_axi_wvalid_o  = w_pend_q;
  assign m_axi_arvalid_o = ar_pend_q;

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Directed bench for axi_lite_cmd_arbiter: vector table plus multi-cycle sequences.
module tb_axi_lite_cmd_arbiter;

  logic         pl_clk = 1'b0;
  logic         pl_rst;
  logic [3:0]   req_valid, req_ready, req_write, rsp_valid;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_wstrb;
  logic [31:0]  rsp_rdata;
  logic [1:0]   rsp_resp, grant_id;
  logic         busy;
  logic [31:0]  m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]   m_wstrb;
  logic         m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic         m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]   m_bresp, m_rresp;

  always #5 pl_clk = ~pl_clk;

  axi_lite_cmd_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .pl_clk_i(pl_clk), .pl_rst_i(pl_rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
    .busy_o(busy), .grant_id_o(grant_id),
    .m_axi_awaddr_o(m_awaddr), .m_axi_awvalid_o(m_awvalid), .m_axi_awready_i(m_awready),
    .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb), .m_axi_wvalid_o(m_wvalid),
    .m_axi_wready_i(m_wready),
    .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid), .m_axi_bready_o(m_bready),
    .m_axi_araddr_o(m_araddr), .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready),
    .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp), .m_axi_rvalid_i(m_rvalid),
    .m_axi_rready_o(m_rready)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Event logs filled by the monitor and slave
  int acc_idx[$], acc_cyc[$];
  int rsp_idx[$], rsp_cyc[$];
  logic [31:0] rsp_rd[$];
  logic [1:0]  rsp_rs[$];

  // Slave knobs and captured beats
  int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'h0;
  int aw_n = 0, w_n = 0, ar_n = 0;
  int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_cyc = 0, r_cyc = 0;
  logic [31:0] aw_addr_c, w_data_c, ar_addr_c;
  logic [3:0]  w_strb_c;

  typedef struct {
    int          req;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] srdata;
    logic [1:0]  sresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs [5];

  function automatic int oh2i(input logic [3:0] v);
    if ($countones(v) != 1) return 99;
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 99;
  endfunction

  task automatic tick();
    @(posedge pl_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_acc(input int target, input int budget);
    for (int t = 0; t < budget && acc_idx.size() < target; t++) tick();
    chk("accept_wait", 32'(acc_idx.size()), 32'(target));
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int t = 0; t < budget && rsp_idx.size() < target; t++) tick();
    chk("rsp_wait", 32'(rsp_idx.size()), 32'(target));
  endtask

  task automatic drive_req(input int k, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    req_write[k]          = wr;
    req_addr[k*32 +: 32]  = addr;
    req_wdata[k*32 +: 32] = wdata;
    req_wstrb[k*4 +: 4]   = strb;
  endtask

  // Monitor: accepts and response pulses, sampled mid-cycle
  initial forever begin
    @(posedge pl_clk);
    cyc++;
  end

  initial forever begin
    @(negedge pl_clk);
    if (!pl_rst) begin
      if (|(req_valid & req_ready)) begin
        acc_idx.push_back(oh2i(req_ready));
        acc_cyc.push_back(cyc);
      end
      if (|rsp_valid) begin
        rsp_idx.push_back(oh2i(rsp_valid));
        rsp_cyc.push_back(cyc);
        rsp_rd.push_back(rsp_rdata);
        rsp_rs.push_back(rsp_resp);
      end
    end
  end

  // AXI4-Lite slave with programmable per-channel latency
  initial begin
    bit hs_aw, hs_w, hs_ar, hs_b, hs_r;
    bit aw_done, w_done, b_pend, r_pend;
    int aw_age, w_age, ar_age, b_age, r_age;
    aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
    aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
    m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
    m_bresp = 0; m_rresp = 0; m_rdata = 0;
    forever begin
      @(negedge pl_clk);
      hs_aw = !pl_rst && m_awvalid && m_awready;
      hs_w  = !pl_rst && m_wvalid && m_wready;
      hs_ar = !pl_rst && m_arvalid && m_arready;
      hs_b  = !pl_rst && m_bvalid && m_bready;
      hs_r  = !pl_rst && m_rvalid && m_rready;
      if (hs_aw) begin aw_n++; aw_cyc = cyc; aw_addr_c = m_awaddr; end
      if (hs_w)  begin w_n++; w_cyc = cyc; w_data_c = m_wdata; w_strb_c = m_wstrb; end
      if (hs_ar) begin ar_n++; ar_cyc = cyc; ar_addr_c = m_araddr; end
      if (hs_b) b_cyc = cyc;
      if (hs_r) r_cyc = cyc;
      @(posedge pl_clk);
      #1;
      if (pl_rst) begin
        aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
        aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
      end else begin
        if (hs_b) b_pend = 0;
        if (hs_r) r_pend = 0;
        if (hs_aw) aw_done = 1;
        if (hs_w) w_done = 1;
        if (aw_done && w_done) begin aw_done = 0; w_done = 0; b_pend = 1; b_age = 0; end
        if (hs_ar) begin r_pend = 1; r_age = 0; end
        if (!m_awvalid) aw_age = 0;
        if (!m_wvalid) w_age = 0;
        if (!m_arvalid) ar_age = 0;
        m_awready = m_awvalid && (aw_age >= aw_lat);
        m_wready  = m_wvalid && (w_age >= w_lat);
        m_arready = m_arvalid && (ar_age >= ar_lat);
        if (m_awvalid) aw_age++;
        if (m_wvalid) w_age++;
        if (m_arvalid) ar_age++;
        m_bvalid = b_pend && (b_age >= b_lat);
        m_rvalid = r_pend && (r_age >= r_lat);
        if (b_pend) b_age++;
        if (r_pend) r_age++;
        m_bresp = s_bresp;
        m_rresp = s_rresp;
        m_rdata = s_rdata;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ba, br, a0, w0, t0;
    pl_rst = 1'b1;
    req_valid = 4'hF; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;

    //         req wr  addr    wdata          strb   slave rdata    resp   exp rdata     exp resp
    vecs[0] = '{0, 1'b1, 32'h8,  32'hA5A5_0001, 4'hF, 32'hDEAD_0000, 2'b00, 32'h0,         2'b00};
    vecs[1] = '{2, 1'b0, 32'h14, 32'h0,         4'h0, 32'h1234_5678, 2'b00, 32'h1234_5678, 2'b00};
    vecs[2] = '{1, 1'b1, 32'h40, 32'h0BAD_F00D, 4'h3, 32'h1111_1111, 2'b10, 32'h0,         2'b10};
    vecs[3] = '{3, 1'b0, 32'h7C, 32'h0,         4'h0, 32'hCAFE_BABE, 2'b10, 32'hCAFE_BABE, 2'b10};
    vecs[4] = '{0, 1'b0, 32'h0,  32'h0,         4'h0, 32'h0000_FFFF, 2'b01, 32'h0000_FFFF, 2'b01};

    // Reset state, with every requester already asking
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h3);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_resp", 32'(rsp_resp), 32'h0);
    chk("rst_axi_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'h0);
    req_valid = '0;
    tick(); tick();
    pl_rst = 1'b0;
    tick();

    // Round robin: all four held high for eight reads
    for (int k = 0; k < 4; k++) drive_req(k, 1'b0, 32'h100 + 32'(k * 4), 32'h0, 4'h0);
    ba = acc_idx.size(); br = rsp_idx.size();
    req_valid = 4'hF;
    wait_acc(ba + 8, 200);
    req_valid = '0;
    wait_rsp(br + 8, 50);
    for (int i = 0; i < 8; i++) begin
      if (ba + i < acc_idx.size()) chk($sformatf("rr_accept%0d", i), 32'(acc_idx[ba+i]), 32'(i % 4));
      if (br + i < rsp_idx.size()) chk($sformatf("rr_rsp%0d", i), 32'(rsp_idx[br+i]), 32'(i % 4));
    end

    // Vector table: single transactions, zero-latency slave
    for (int v = 0; v < 5; v++) begin
      s_bresp = vecs[v].sresp; s_rresp = vecs[v].sresp; s_rdata = vecs[v].srdata;
      ba = acc_idx.size(); br = rsp_idx.size();
      drive_req(vecs[v].req, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb);
      req_valid = 4'(1 << vecs[v].req);
      wait_acc(ba + 1, 20);
      req_valid = '0;
      wait_rsp(br + 1, 40);
      if (acc_idx.size() > ba && rsp_idx.size() > br) begin
        chk($sformatf("v%0d_acc_idx", v), 32'(acc_idx[ba]), 32'(vecs[v].req));
        chk($sformatf("v%0d_rsp_idx", v), 32'(rsp_idx[br]), 32'(vecs[v].req));
        chk($sformatf("v%0d_rdata", v), rsp_rd[br], vecs[v].exp_rdata);
        chk($sformatf("v%0d_resp", v), 32'(rsp_rs[br]), 32'(vecs[v].exp_resp));
        if (vecs[v].wr) begin
          chk($sformatf("v%0d_awaddr", v), aw_addr_c, vecs[v].addr);
          chk($sformatf("v%0d_wdata", v), w_data_c, vecs[v].wdata);
          chk($sformatf("v%0d_wstrb", v), 32'(w_strb_c), 32'(vecs[v].strb));
          chk($sformatf("v%0d_aw_lat", v), 32'(aw_cyc - acc_cyc[ba]), 32'd1);
          chk($sformatf("v%0d_rsp_lat", v), 32'(rsp_cyc[br] - b_cyc), 32'd1);
        end else begin
          chk($sformatf("v%0d_araddr", v), ar_addr_c, vecs[v].addr);
          chk($sformatf("v%0d_ar_lat", v), 32'(ar_cyc - acc_cyc[ba]), 32'd1);
          chk($sformatf("v%0d_rsp_lat", v), 32'(rsp_cyc[br] - r_cyc), 32'd1);
        end
      end
    end

    // Split handshake: W accepted three cycles after AW
    s_bresp = 2'b00; aw_lat = 0; w_lat = 3;
    ba = acc_idx.size(); br = rsp_idx.size(); a0 = aw_n; w0 = w_n;
    drive_req(3, 1'b1, 32'h20, 32'h5555_AAAA, 4'hC);
    req_valid = 4'b1000;
    wait_acc(ba + 1, 20);
    req_valid = '0;
    wait_rsp(br + 1, 40);
    for (int t = 0; t < 5; t++) tick();
    chk("split_aw_beats", 32'(aw_n - a0), 32'd1);
    chk("split_w_beats", 32'(w_n - w0), 32'd1);
    chk("split_w_gap", 32'(w_cyc - aw_cyc), 32'd3);
    chk("split_wdata", w_data_c, 32'h5555_AAAA);
    if (rsp_idx.size() > br) begin
      chk("split_rsp_idx", 32'(rsp_idx[br]), 32'd3);
      chk("split_rsp_resp", 32'(rsp_rs[br]), 32'd0);
      chk("split_rsp_lat", 32'(rsp_cyc[br] - b_cyc), 32'd1);
    end
    w_lat = 0;

    // Timeout: B withheld until accept+40, then drained silently
    b_lat = 38; s_rdata = 32'h600D_F00D; s_rresp = 2'b00;
    ba = acc_idx.size(); br = rsp_idx.size();
    drive_req(0, 1'b1, 32'h30, 32'h0000_0030, 4'hF);
    req_valid = 4'b0001;
    wait_acc(ba + 1, 20);
    req_valid = '0;
    if (acc_idx.size() > ba) begin
      t0 = acc_cyc[ba];
      for (int t = 0; t < 80 && cyc < t0 + 50; t++) begin
        tick();
        if (cyc == t0 + 20) begin
          drive_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
          req_valid = 4'b0010;
        end
        if (cyc == t0 + 30) chk("to_busy_drain", 32'(busy), 32'h1);
        if (acc_idx.size() > ba + 1) req_valid = '0;
      end
      chk("to_rsp_count", 32'(rsp_idx.size() - br), 32'd2);
      chk("to_late_b", 32'(b_cyc - t0), 32'd40);
      if (rsp_idx.size() > br + 1 && acc_idx.size() > ba + 1) begin
        chk("to_rsp_idx", 32'(rsp_idx[br]), 32'd0);
        chk("to_rsp_at", 32'(rsp_cyc[br] - t0), 32'd17);
        chk("to_rsp_resp", 32'(rsp_rs[br]), 32'h3);
        chk("to_rsp_rdata", rsp_rd[br], 32'h0);
        chk("to_next_acc_at", 32'(acc_cyc[ba+1] - t0), 32'd41);
        chk("to_next_acc_idx", 32'(acc_idx[ba+1]), 32'd1);
        chk("to_next_rsp_idx", 32'(rsp_idx[br+1]), 32'd1);
        chk("to_next_rdata", rsp_rd[br+1], 32'h600D_F00D);
      end
    end
    req_valid = '0;
    b_lat = 0;
    tick();

    // Asynchronous reset while waiting in RESP
    b_lat = 5; s_bresp = 2'b00;
    ba = acc_idx.size();
    drive_req(2, 1'b1, 32'h50, 32'h0000_0050, 4'hF);
    drive_req(3, 1'b1, 32'h54, 32'h0000_0054, 4'hF);
    drive_req(0, 1'b1, 32'h58, 32'h0000_0058, 4'hF);
    req_valid = 4'b0100;
    wait_acc(ba + 1, 20);
    req_valid = 4'b1000;
    for (int t = 0; t < 20 && !m_bready; t++) tick();
    chk("rr_bready_wait", 32'(m_bready), 32'h1);
    chk("resp_no_ready", 32'(req_ready), 32'h0);
    #2;
    pl_rst = 1'b1;
    #1;
    br = rsp_idx.size();
    chk("arst_axi_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'h0);
    chk("arst_req_ready", 32'(req_ready), 32'h0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_grant_id", 32'(grant_id), 32'h3);
    b_lat = 0;
    tick(); tick();
    pl_rst = 1'b0;
    ba = acc_idx.size();
    req_valid = 4'b1001;
    wait_acc(ba + 1, 20);
    req_valid = '0;
    wait_rsp(br + 1, 40);
    if (acc_idx.size() > ba) chk("post_rst_first", 32'(acc_idx[ba]), 32'd0);
    if (rsp_idx.size() > br) chk("post_rst_rsp_idx", 32'(rsp_idx[br]), 32'd0);
    for (int t = 0; t < 4; t++) tick();
    chk("post_rst_rsp_count", 32'(rsp_idx.size() - br), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
